// File: rtl/s27kl0642_hyperram_if.sv
// s27kl0642_hyperram_if
//   HyperBus device-side signal bundle.
//   ck       HyperBus clock from the controller
//   cs_n     chip select, active low
//   dq_i     DQ driven by the controller
//   dq_o     DQ driven by the device, with dq_oe
//   rwds_i   RWDS from the controller (write byte mask)
//   rwds_o   RWDS driven by the device, with rwds_oe
//   master:  controller view, slave: device view
`timescale 1ns/1ps
interface s27kl0642_hyperram_if;
  logic       ck;
  logic       cs_n;
  logic [7:0] dq_i;
  logic [7:0] dq_o;
  logic       dq_oe;
  logic       rwds_i;
  logic       rwds_o;
  logic       rwds_oe;

  modport master (
    output ck, cs_n, dq_i, rwds_i,
    input  dq_o, dq_oe, rwds_o, rwds_oe
  );

  modport slave (
    input  ck, cs_n, dq_i, rwds_i,
    output dq_o, dq_oe, rwds_o, rwds_oe
  );
endinterface

// File: rtl/s27kl0642_hyperram.sv
// s27kl0642_hyperram
//   Behavioural HyperRAM device (S27KL0642-class) scaled to 2^ADDR_W 16-bit
//   words. The HyperBus CK/CS#/DQ/RWDS inputs are oversampled by clk (>= 4x
//   CK); every CK transition while CS# is low is one "edge". Decodes the 48-bit
//   CA, then serves memory/register reads and writes with CR0-selected initial
//   latency, RWDS write masking and RWDS read strobing.
// Ports:
//   clk  system clock, all logic on its rising edge
//   rst  synchronous active-high reset (reloads CR0/CR1, memory kept)
//   hb   HyperBus device-side interface (slave modport)
// Build option:
//   HBRAM_WRAP_BURST_EN  when defined, CA[45]=0 selects a wrapped burst whose
//                        group size comes from CR0[1:0]; when undefined all
//                        bursts are linear and CR0[1:0] is storage only.
`timescale 1ns/1ps
module s27kl0642_hyperram #(
  parameter int unsigned ADDR_W  = 10,
  parameter logic [15:0] ID0_VAL = 16'h0C81,
  parameter logic [15:0] ID1_VAL = 16'h0000,
  parameter logic [15:0] CR0_RST = 16'h8F1F,
  parameter logic [15:0] CR1_RST = 16'hFFC1
) (
  input logic                 clk,
  input logic                 rst,
  s27kl0642_hyperram_if.slave hb
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CA   = 2'd1;
  localparam logic [1:0] ST_LAT  = 2'd2;
  localparam logic [1:0] ST_DATA = 2'd3;

  logic [15:0] mem [0:(1<<ADDR_W)-1];

  logic              ck_q;
  logic [1:0]        state_q, state_d;
  logic [5:0]        edge_cnt_q, edge_cnt_d;
  logic [39:0]       ca_q, ca_d;
  logic              is_read_q, is_read_d;
  logic              is_reg_q, is_reg_d;
  logic              is_lin_q, is_lin_d;
  logic [31:0]       addr_q, addr_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [7:0]        reg_hi_q, reg_hi_d;
  logic              reg_done_q, reg_done_d;
  logic [15:0]       cr0_q, cr0_d;
  logic [15:0]       cr1_q, cr1_d;
  logic [7:0]        dq_o_q, dq_o_d;
  logic              dq_oe_q, dq_oe_d;
  logic              rwds_o_q, rwds_o_d;
  logic              rwds_oe_q, rwds_oe_d;

  logic              ck_edge;
  logic [5:0]        edge_num;
  logic [47:0]       ca_full;
  logic [31:0]       ca_addr;
  logic [3:0]        lat_l;
  logic [4:0]        lat_eff;
  logic [5:0]        first_data_edge;
  logic              data_edge;
  logic [ADDR_W-1:0] next_maddr;
  logic [15:0]       reg_word;
  logic [15:0]       rd_word;
  logic              mem_we_hi;
  logic              mem_we_lo;
  logic              ca_unused;

  assign ck_edge  = (hb.ck != ck_q) && !hb.cs_n;
  assign edge_num = edge_cnt_q + 6'd1;
  assign ca_full  = {ca_q, hb.dq_i};
  assign ca_addr  = {ca_full[44:16], ca_full[2:0]};

  // Initial latency in CK cycles from CR0[7:4]; reserved codes behave as 6.
  always_comb begin
    case (cr0_q[7:4])
      4'b0000: lat_l = 4'd5;
      4'b0001: lat_l = 4'd6;
      4'b1110: lat_l = 4'd3;
      4'b1111: lat_l = 4'd4;
      default: lat_l = 4'd6;
    endcase
  end

  assign lat_eff         = cr0_q[3] ? {lat_l, 1'b0} : {1'b0, lat_l};
  assign first_data_edge = {lat_eff, 1'b0} + 6'd5;

  // The edge that carries the first data byte still arrives while in LAT,
  // so it is treated as a data edge together with every edge in DATA.
  assign data_edge = ck_edge &&
                     ((state_q == ST_DATA) ||
                      ((state_q == ST_LAT) && (edge_num == first_data_edge)));

`ifdef HBRAM_WRAP_BURST_EN
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] inc_maddr;

  always_comb begin
    case (cr0_q[1:0])
      2'b00:   wrap_mask = ADDR_W'(63);
      2'b01:   wrap_mask = ADDR_W'(31);
      2'b10:   wrap_mask = ADDR_W'(7);
      default: wrap_mask = ADDR_W'(15);
    endcase
  end

  assign inc_maddr  = maddr_q + 1'b1;
  assign next_maddr = is_lin_q ? inc_maddr
                               : ((maddr_q & ~wrap_mask) | (inc_maddr & wrap_mask));
  assign ca_unused  = ^ca_full[15:3];
`else
  assign next_maddr = maddr_q + 1'b1;
  assign ca_unused  = ^{ca_full[15:3], is_lin_q};
`endif

  always_comb begin
    case (addr_q)
      32'h0000_0000: reg_word = ID0_VAL;
      32'h0000_0001: reg_word = ID1_VAL;
      32'h0000_0800: reg_word = cr0_q;
      32'h0000_0801: reg_word = cr1_q;
      default:       reg_word = '0;
    endcase
  end

  assign rd_word = is_reg_q ? reg_word : mem[maddr_q];

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    ca_d       = ca_q;
    is_read_d  = is_read_q;
    is_reg_d   = is_reg_q;
    is_lin_d   = is_lin_q;
    addr_d     = addr_q;
    maddr_d    = maddr_q;
    reg_hi_d   = reg_hi_q;
    reg_done_d = reg_done_q;
    cr0_d      = cr0_q;
    cr1_d      = cr1_q;
    dq_o_d     = dq_o_q;
    dq_oe_d    = dq_oe_q;
    rwds_o_d   = rwds_o_q;
    rwds_oe_d  = rwds_oe_q;
    mem_we_hi  = 1'b0;
    mem_we_lo  = 1'b0;

    if (hb.cs_n) begin
      state_d    = ST_IDLE;
      edge_cnt_d = '0;
      reg_done_d = 1'b0;
      dq_o_d     = '0;
      dq_oe_d    = 1'b0;
      rwds_o_d   = 1'b0;
      rwds_oe_d  = 1'b0;
    end else if (ck_edge) begin
      case (state_q)
        ST_IDLE: begin
          // A falling CK while selected is not edge 1; wait for a rising one.
          if (hb.ck) begin
            ca_d       = {ca_q[31:0], hb.dq_i};
            edge_cnt_d = 6'd1;
            state_d    = ST_CA;
            rwds_oe_d  = 1'b1;
            rwds_o_d   = cr0_q[3];
          end
        end
        ST_CA: begin
          ca_d       = {ca_q[31:0], hb.dq_i};
          edge_cnt_d = edge_num;
          if (edge_num == 6'd6) begin
            is_read_d  = ca_full[47];
            is_reg_d   = ca_full[46];
            is_lin_d   = ca_full[45];
            addr_d     = ca_addr;
            maddr_d    = ca_addr[ADDR_W-1:0];
            reg_done_d = 1'b0;
            rwds_oe_d  = ca_full[47];
            rwds_o_d   = 1'b0;
            // Register writes carry no latency: data follows on edges 7-8.
            state_d    = (!ca_full[47] && ca_full[46]) ? ST_DATA : ST_LAT;
          end
        end
        ST_LAT: begin
          edge_cnt_d = edge_num;
          if (edge_num == first_data_edge) begin
            state_d = ST_DATA;
          end
        end
        default: ;
      endcase

      // Rising CK edges carry the upper byte, falling edges the lower byte.
      if (data_edge) begin
        if (is_read_q) begin
          dq_oe_d  = 1'b1;
          rwds_o_d = hb.ck;
          dq_o_d   = hb.ck ? rd_word[15:8] : rd_word[7:0];
          if (!hb.ck && !is_reg_q) begin
            maddr_d = next_maddr;
          end
        end else if (is_reg_q) begin
          if (!reg_done_q) begin
            if (hb.ck) begin
              reg_hi_d = hb.dq_i;
            end else begin
              reg_done_d = 1'b1;
              if (addr_q == 32'h0000_0800) begin
                cr0_d = {reg_hi_q, hb.dq_i};
              end else if (addr_q == 32'h0000_0801) begin
                cr1_d = {reg_hi_q, hb.dq_i};
              end
            end
          end
        end else begin
          // Each byte lands in memory on its own edge, so a burst cut short
          // by CS# keeps every byte already transferred.
          mem_we_hi = hb.ck && !hb.rwds_i;
          mem_we_lo = !hb.ck && !hb.rwds_i;
          if (!hb.ck) begin
            maddr_d = next_maddr;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ck_q       <= 1'b0;
      state_q    <= ST_IDLE;
      edge_cnt_q <= '0;
      ca_q       <= '0;
      is_read_q  <= 1'b0;
      is_reg_q   <= 1'b0;
      is_lin_q   <= 1'b1;
      addr_q     <= '0;
      maddr_q    <= '0;
      reg_hi_q   <= '0;
      reg_done_q <= 1'b0;
      cr0_q      <= CR0_RST;
      cr1_q      <= CR1_RST;
      dq_o_q     <= '0;
      dq_oe_q    <= 1'b0;
      rwds_o_q   <= 1'b0;
      rwds_oe_q  <= 1'b0;
    end else begin
      ck_q       <= hb.ck;
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      ca_q       <= ca_d;
      is_read_q  <= is_read_d;
      is_reg_q   <= is_reg_d;
      is_lin_q   <= is_lin_d;
      addr_q     <= addr_d;
      maddr_q    <= maddr_d;
      reg_hi_q   <= reg_hi_d;
      reg_done_q <= reg_done_d;
      cr0_q      <= cr0_d;
      cr1_q      <= cr1_d;
      dq_o_q     <= dq_o_d;
      dq_oe_q    <= dq_oe_d;
      rwds_o_q   <= rwds_o_d;
      rwds_oe_q  <= rwds_oe_d;
    end
  end

  // Memory has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we_hi) begin
      mem[maddr_q][15:8] <= hb.dq_i;
    end
    if (mem_we_lo) begin
      mem[maddr_q][7:0] <= hb.dq_i;
    end
  end

  assign hb.dq_o    = dq_o_q;
  assign hb.dq_oe   = dq_oe_q;
  assign hb.rwds_o  = rwds_o_q;
  assign hb.rwds_oe = rwds_oe_q;

endmodule

// File: tb/tb_s27kl0642_hyperram.sv
// tb_s27kl0642_hyperram
//   Directed bench for s27kl0642_hyperram. Acts as the HyperBus controller with
//   CK at 1/8 of clk; inputs change on clk falling edges and device outputs
//   are sampled one clk after each CK transition.
`timescale 1ns/1ps
module tb_s27kl0642_hyperram;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  s27kl0642_hyperram_if hb ();

  s27kl0642_hyperram #(
    .ADDR_W (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hb  (hb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [7:0]  s_dq;
  logic        s_dq_oe;
  logic        s_rwds;
  logic        s_rwds_oe;
  logic        exp_2x;
  int          lat_first;
  logic [15:0] exp_w[$];
  logic [7:0]  wb[$];
  logic        wm[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [47:0] mk_ca(input logic rd, input logic rg, input logic lin,
                                        input logic [31:0] a);
    logic [47:0] c;
    c         = '0;
    c[47]     = rd;
    c[46]     = rg;
    c[45]     = lin;
    c[44:16]  = a[31:3];
    c[2:0]    = a[2:0];
    return c;
  endfunction

  // One CK transition; samples device outputs one clk later.
  task automatic hb_edge(input logic [7:0] d, input logic m);
    hb.ck     = ~hb.ck;
    hb.dq_i   = d;
    hb.rwds_i = m;
    @(negedge clk);
    s_dq      = hb.dq_o;
    s_dq_oe   = hb.dq_oe;
    s_rwds    = hb.rwds_o;
    s_rwds_oe = hb.rwds_oe;
    repeat (3) @(negedge clk);
  endtask

  task automatic hb_begin();
    hb.ck   = 1'b0;
    hb.cs_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic hb_end(input string tag);
    hb.cs_n = 1'b1;
    @(negedge clk);
    check({tag, "_end_dq_oe"},   hb.dq_oe,   1'b0);
    check({tag, "_end_rwds_oe"}, hb.rwds_oe, 1'b0);
    check({tag, "_end_dq_o"},    hb.dq_o,    8'h00);
    check({tag, "_end_rwds_o"},  hb.rwds_o,  1'b0);
    hb.ck = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic hb_ca(input logic [47:0] ca, input string tag, input logic chk);
    logic [47:0] c;
    c = ca;
    for (int i = 0; i < 6; i++) begin
      hb_edge(c[47-8*i -: 8], 1'b0);
      if (chk && i == 2) begin
        check({tag, "_ca_rwds_oe"}, s_rwds_oe, 1'b1);
        check({tag, "_ca_rwds_o"},  s_rwds,    exp_2x);
      end
    end
  endtask

  // Read exp_w.size() words; first data byte expected on edge 'first'.
  task automatic hb_read(input string tag, input logic rg, input logic lin,
                         input logic [31:0] a, input int first);
    hb_begin();
    hb_ca(mk_ca(1'b1, rg, lin, a), tag, 1'b1);
    for (int e = 7; e < first; e++) hb_edge(8'h00, 1'b0);
    check({tag, "_lat_dq_oe"},   s_dq_oe,   1'b0);
    check({tag, "_lat_rwds_o"},  s_rwds,    1'b0);
    check({tag, "_lat_rwds_oe"}, s_rwds_oe, 1'b1);
    for (int w = 0; w < exp_w.size(); w++) begin
      hb_edge(8'h00, 1'b0);
      check($sformatf("%s_w%0d_hi", tag, w),      s_dq,    exp_w[w][15:8]);
      check($sformatf("%s_w%0d_rwds_hi", tag, w), s_rwds,  1'b1);
      check($sformatf("%s_w%0d_dq_oe", tag, w),   s_dq_oe, 1'b1);
      hb_edge(8'h00, 1'b0);
      check($sformatf("%s_w%0d_lo", tag, w),      s_dq,    exp_w[w][7:0]);
      check($sformatf("%s_w%0d_rwds_lo", tag, w), s_rwds,  1'b0);
    end
    hb_end(tag);
  endtask

  // Write the bytes in wb with masks wm, first byte on edge 'first'.
  task automatic hb_write(input string tag, input logic rg, input logic [31:0] a,
                          input int first);
    hb_begin();
    hb_ca(mk_ca(1'b0, rg, 1'b1, a), tag, 1'b0);
    for (int e = 7; e < first; e++) hb_edge(8'h00, 1'b0);
    for (int b = 0; b < wb.size(); b++) hb_edge(wb[b], wm[b]);
    check({tag, "_wr_rwds_oe"}, s_rwds_oe, 1'b0);
    check({tag, "_wr_dq_oe"},   s_dq_oe,   1'b0);
    hb_end(tag);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    hb.ck     = 1'b0;
    hb.cs_n   = 1'b1;
    hb.dq_i   = 8'h00;
    hb.rwds_i = 1'b0;
    exp_2x    = 1'b1;
    lat_first = 29;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_dq_oe",   hb.dq_oe,   1'b0);
    check("rst_rwds_oe", hb.rwds_oe, 1'b0);
    check("rst_dq_o",    hb.dq_o,    8'h00);
    check("rst_rwds_o",  hb.rwds_o,  1'b0);

    exp_w = '{16'h0C81};
    hb_read("id0", 1'b1, 1'b1, 32'h0, lat_first);
    exp_w = '{16'h8F1F};
    hb_read("cr0_rst", 1'b1, 1'b1, 32'h800, lat_first);

    wb = '{8'h12, 8'h34, 8'h56, 8'h78};
    wm = '{1'b0, 1'b0, 1'b0, 1'b0};
    hb_write("wr10", 1'b0, 32'h10, lat_first);
    exp_w = '{16'h1234, 16'h5678};
    hb_read("rd10", 1'b0, 1'b1, 32'h10, lat_first);

    wb = '{8'hAA, 8'hBB};
    wm = '{1'b1, 1'b0};
    hb_write("wrmask", 1'b0, 32'h10, lat_first);
    exp_w = '{16'h12BB};
    hb_read("rdmask", 1'b0, 1'b1, 32'h10, lat_first);

    wb = '{8'h8F, 8'h07};
    wm = '{1'b0, 1'b0};
    hb_write("wrcr0", 1'b1, 32'h800, 7);
    exp_2x    = 1'b0;
    lat_first = 15;
    exp_w = '{16'h8F07};
    hb_read("cr0_new", 1'b1, 1'b1, 32'h800, lat_first);
    exp_w = '{16'h12BB};
    hb_read("rd_lat5", 1'b0, 1'b1, 32'h10, lat_first);

    wb = '{8'hA0, 8'h00, 8'hA0, 8'h01};
    wm = '{1'b0, 1'b0, 1'b0, 1'b0};
    hb_write("wr00", 1'b0, 32'h00, lat_first);
    wb = '{8'hE0, 8'h0E, 8'hE0, 8'h0F};
    hb_write("wr0e", 1'b0, 32'h0E, lat_first);
`ifdef HBRAM_WRAP_BURST_EN
    exp_w = '{16'hE00E, 16'hE00F, 16'hA000, 16'hA001};
`else
    exp_w = '{16'hE00E, 16'hE00F, 16'h12BB, 16'h5678};
`endif
    hb_read("rdwrap", 1'b0, 1'b0, 32'h0E, lat_first);

    wb = '{8'h00, 8'h00, 8'h11, 8'h11};
    hb_write("wr20", 1'b0, 32'h20, lat_first);
    wb = '{8'hDE, 8'hAD, 8'hBE};
    wm = '{1'b0, 1'b0, 1'b0};
    hb_write("wrabort", 1'b0, 32'h20, lat_first);
    exp_w = '{16'hDEAD, 16'hBE11};
    hb_read("rdabort", 1'b0, 1'b1, 32'h20, lat_first);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_2x    = 1'b1;
    lat_first = 29;
    exp_w = '{16'h8F1F};
    hb_read("cr0_reload", 1'b1, 1'b1, 32'h800, lat_first);
    exp_w = '{16'h12BB};
    hb_read("mem_kept", 1'b0, 1'b1, 32'h10, lat_first);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
